dmem_access_ctrl: RTL

// - Data-memory access controller directly upstream of the load-extract stage: takes core load/store requests,

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/store_lane_align.sv | 24 ++
 rtl/dmem_access_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access controller: width codes,
// controller states, byte-enable generation and alignment legality.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    ERR
  } state_t;

  localparam int unsigned TIMER_W = 8;

  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 4'b0001 << off;
      3'b001, 3'b101: return 4'b0011 << off;
      default:        return 4'b1111;
    endcase
  endfunction

  // Unsigned variants share the alignment rule of their signed counterparts.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
    case (load_f3_e'(f3))
      LB, LBU: return 1'b1;
      LH, LHU: return ~off[0];
      LW:      return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane alignment: byte enables and width-replicated write data.
module store_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  assign be_o = be_gen(funct3_i, addr_lo_i);

  // Replicating the narrow datum into every lane places it under whichever enable is set.
  always_comb begin
    wdata_o = wdata_i;
    case (funct3_i)
      3'b000, 3'b100: wdata_o = {4{wdata_i[7:0]}};
      3'b001, 3'b101: wdata_o = {2{wdata_i[15:0]}};
      default:        wdata_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts core load/store requests, runs one
// handshaked word-aligned bus transfer and returns the raw word to load extract.
module dmem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] drdata_o,
  output logic [31:0] daddr_o,
  output logic        load_valid_o,
  output logic        mem_fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               bus_req_q, bus_req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        drdata_q, drdata_d;
  logic [31:0]        daddr_q, daddr_d;

  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;

  store_lane_align u_lane (
    .funct3_i  (funct3_i),
    .addr_lo_i (addr_i[1:0]),
    .wdata_i   (wdata_i),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bus_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      drdata_q  <= '0;
      daddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bus_req_q <= bus_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      drdata_q  <= drdata_d;
      daddr_q   <= daddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bus_req_d = bus_req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    drdata_d  = drdata_q;
    daddr_d   = daddr_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (mem_req_i) begin
          if (!access_ok(funct3_i, addr_i[1:0])) begin
            state_d = ERR;
          end else begin
            addr_d    = addr_i;
            we_d      = mem_we_i;
            be_d      = mem_we_i ? lane_be : 4'b1111;
            wdata_d   = lane_wdata;
            bus_req_d = 1'b1;
            state_d   = BUSY;
          end
        end
      end
      // A ready in the final timeout cycle still completes the transfer.
      BUSY: begin
        if (bus_ready_i) begin
          bus_req_d = 1'b0;
          timer_d   = '0;
          state_d   = RESP;
          if (!we_q) begin
            drdata_d = bus_rdata_i;
            daddr_d  = addr_q;
          end
        end else if (timer_q == TimerLast) begin
          bus_req_d = 1'b0;
          timer_d   = '0;
          state_d   = ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the combinational request term so stall drops with reset even if mem_req is held.
  assign stall_o      = rst_ni & ((mem_req_i & (state_q == IDLE)) | (state_q == BUSY));
  assign load_valid_o = (state_q == RESP) & ~we_q;
  assign mem_fault_o  = (state_q == ERR);
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_req_q & we_q;
  assign bus_addr_o   = {addr_q[31:2], 2'b00};
  assign bus_be_o     = be_q;
  assign bus_wdata_o  = wdata_q;
  assign drdata_o     = drdata_q;
  assign daddr_o      = daddr_q;

endmodule
